// File: rtl/lab2_proc_imul_pkg.sv
// ---------------------------------------------------------------------------
// lab2_proc_imul_pkg
//   Shared definitions for the iterative 32-bit multiplier:
//     - IMUL_NBITS           : datapath width
//     - IMUL_REQ_*           : bit offsets of a / b inside the 64-bit request
//     - imul_state_e         : control FSM states
//     - imul_dpath_op_e      : operation the control asks the datapath to do
// ---------------------------------------------------------------------------
package lab2_proc_imul_pkg;

  localparam int IMUL_NBITS     = 32;

  localparam int IMUL_REQ_A_MSB = 63;
  localparam int IMUL_REQ_A_LSB = 32;
  localparam int IMUL_REQ_B_MSB = 31;
  localparam int IMUL_REQ_B_LSB = 0;

  typedef enum logic [1:0] {
    IMUL_IDLE = 2'd0,
    IMUL_CALC = 2'd1,
    IMUL_DONE = 2'd2
  } imul_state_e;

  // HOLD keeps every register, LOAD captures fresh operands and clears the
  // accumulator, STEP performs one shift-and-add iteration.
  typedef enum logic [1:0] {
    IMUL_OP_HOLD = 2'd0,
    IMUL_OP_LOAD = 2'd1,
    IMUL_OP_STEP = 2'd2
  } imul_dpath_op_e;

endpackage

// File: rtl/lab2_proc_imul_iter_dpath.sv
// ---------------------------------------------------------------------------
// lab2_proc_imul_iter_dpath
//   Shift-and-add datapath of the iterative multiplier. Holds the operand
//   shift registers and the accumulator; the control FSM picks the operation.
//
//   Ports:
//     clk, reset      rising-edge clock, synchronous active-high reset
//     op_i            HOLD / LOAD / STEP from the control FSM
//     a_i, b_i        operands captured on LOAD
//     b_next_zero_o   no set bits remain in b above bit 0 (last iteration)
//     b_lsb_o         current bit 0 of b (accumulate this cycle)
//     result_o        accumulator, the low 32 bits of the running product
// ---------------------------------------------------------------------------
module lab2_proc_imul_iter_dpath
  import lab2_proc_imul_pkg::*;
(
  input  logic                  clk,
  input  logic                  reset,
  input  imul_dpath_op_e        op_i,
  input  logic [IMUL_NBITS-1:0] a_i,
  input  logic [IMUL_NBITS-1:0] b_i,
  output logic                  b_next_zero_o,
  output logic                  b_lsb_o,
  output logic [IMUL_NBITS-1:0] result_o
);

  logic [IMUL_NBITS-1:0] a_q,      a_d;
  logic [IMUL_NBITS-1:0] b_q,      b_d;
  logic [IMUL_NBITS-1:0] result_q, result_d;
  logic [IMUL_NBITS-1:0] sum;

  // Accumulator adder; the carry out is dropped so the product wraps mod 2^32.
  assign sum = result_q + a_q;

  // NOTE: every always_comb output gets a default first so no path through
  // the case leaves it unassigned, which would otherwise infer a latch.
  always_comb begin
    a_d      = a_q;
    b_d      = b_q;
    result_d = result_q;
    unique case (op_i)
      IMUL_OP_LOAD: begin
        a_d      = a_i;
        b_d      = b_i;
        result_d = '0;
      end
      IMUL_OP_STEP: begin
        a_d = a_q << 1;
        b_d = b_q >> 1;
        if (b_q[0]) result_d = sum;
      end
      default: ;
    endcase
  end

  // NOTE: the datapath registers are cleared on reset (not left undefined)
  // so resp_msg reads 0 straight out of reset.
  always_ff @(posedge clk) begin
    if (reset) begin
      a_q      <= '0;
      b_q      <= '0;
      result_q <= '0;
    end else begin
      a_q      <= a_d;
      b_q      <= b_d;
      result_q <= result_d;
    end
  end

  // Looks one shift ahead so the FSM leaves CALC in the same cycle as the
  // final accumulate instead of spending an extra cycle on b == 0.
  assign b_next_zero_o = (b_q[IMUL_NBITS-1:1] == '0);
  assign b_lsb_o       = b_q[0];
  assign result_o      = result_q;

endmodule

// File: rtl/lab2_proc_imul_iter.sv
// ---------------------------------------------------------------------------
// lab2_proc_imul_iter
//   Iterative variable-latency 32x32 -> low-32 multiplier for the X stage.
//   Latency from acceptance to resp_val is (index of MSB set in b) + 2.
//
//   Ports:
//     clk, reset   rising-edge clock, synchronous active-high reset
//     req_val/rdy  request handshake; req_rdy high only in IDLE
//     req_msg      {a[63:32], b[31:0]}
//     resp_val/rdy response handshake; resp_val high only in DONE
//     resp_msg     low 32 bits of a*b, stable while resp_val is high
//     squash       aborts any in-flight multiply, blocks acceptance in IDLE
// ---------------------------------------------------------------------------
module lab2_proc_imul_iter
  import lab2_proc_imul_pkg::*;
(
  input  logic                    clk,
  input  logic                    reset,
  input  logic                    req_val,
  output logic                    req_rdy,
  input  logic [2*IMUL_NBITS-1:0] req_msg,
  output logic                    resp_val,
  input  logic                    resp_rdy,
  output logic [IMUL_NBITS-1:0]   resp_msg,
  input  logic                    squash
);

  imul_state_e    state_q, state_d;
  logic           req_rdy_q;
  logic           resp_val_q;
  imul_dpath_op_e dpath_op;
  logic           b_next_zero;
  logic           b_lsb;

  lab2_proc_imul_iter_dpath u_dpath (
    .clk           (clk),
    .reset         (reset),
    .op_i          (dpath_op),
    .a_i           (req_msg[IMUL_REQ_A_MSB:IMUL_REQ_A_LSB]),
    .b_i           (req_msg[IMUL_REQ_B_MSB:IMUL_REQ_B_LSB]),
    .b_next_zero_o (b_next_zero),
    .b_lsb_o       (b_lsb),
    .result_o      (resp_msg)
  );

  // Next-state and datapath operation. Squash overrides every transition and
  // suppresses the operand load, so a squashed IDLE cycle accepts nothing.
  always_comb begin
    state_d  = state_q;
    dpath_op = IMUL_OP_HOLD;
    if (squash) begin
      state_d = IMUL_IDLE;
    end else begin
      unique case (state_q)
        IMUL_IDLE: if (req_val) begin
          state_d  = IMUL_CALC;
          dpath_op = IMUL_OP_LOAD;
        end
        IMUL_CALC: begin
          dpath_op = IMUL_OP_STEP;
          if (b_next_zero) state_d = IMUL_DONE;
        end
        IMUL_DONE: if (resp_rdy) state_d = IMUL_IDLE;
        default:   state_d = IMUL_IDLE;
      endcase
    end
  end

  // Handshake outputs are registered from the next state, so they always
  // equal a decode of state_q and no input reaches an output combinationally.
  // NOTE: sequential state uses non-blocking assignments so all registers
  // update together from values sampled before the edge.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q    <= IMUL_IDLE;
      req_rdy_q  <= 1'b1;
      resp_val_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      req_rdy_q  <= (state_d == IMUL_IDLE);
      resp_val_q <= (state_d == IMUL_DONE);
    end
  end

  assign req_rdy  = req_rdy_q;
  assign resp_val = resp_val_q;

  // b_lsb is consumed inside the datapath; it is exported for visibility.
  logic unused_b_lsb;
  assign unused_b_lsb = b_lsb;

endmodule
